// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdram_arb_pkg : shared types for the two-master SDRAM port arbiter  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sdram_arb_pkg;

   typedef logic master_id_t;

   localparam master_id_t ID_M0 = 1'b0;
   localparam master_id_t ID_M1 = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT0 = 2'd1,
      GRANT1 = 2'd2
   } arb_state_t;

   function automatic master_id_t other_id(input master_id_t id);
      return ~id;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_port_arbiter_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arb_id_fifo : read-ID FIFO, push and pop allowed in the same cycle  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module arb_id_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head
);

   localparam int c_idx_w = $clog2(DEPTH);
   localparam int c_ptr_w = c_idx_w + 1;

   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [WIDTH-1:0]   r_mem [DEPTH];
   logic               w_do_push;
   logic               w_do_pop;

   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[c_ptr_w-1] != r_rd_ptr[c_ptr_w-1]) &&
                      (r_wr_ptr[c_idx_w-1:0] == r_rd_ptr[c_idx_w-1:0]);
   assign w_do_pop  = i_pop & ~o_empty;
   // A pop in the same cycle frees the slot, so a push at full is still legal.
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_head    = r_mem[r_rd_ptr[c_idx_w-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[c_idx_w-1:0]] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sdram_port_arbiter : round-robin two-master Avalon-MM SDRAM arbiter |
// | Optional statistics: define SDRAM_ARB_STATS_EN            Rev 1.0   |
// +--------------------------------------------------------------------+
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W      = 24,
   parameter int DATA_W      = 32,
   parameter int MAX_PEND    = 8,
   parameter int BURST_LIMIT = 16
) (
   input  logic                clk_clk,
   input  logic                reset_reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   output logic                m0_readdatavalid,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic                m1_readdatavalid,
   output logic [ADDR_W-1:0]   s_address,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   output logic                s_read,
   output logic                s_write,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   input  logic                s_readdatavalid
`ifdef SDRAM_ARB_STATS_EN
   ,
   input  logic                stat_clear,
   output logic [31:0]         stat_m0_grants,
   output logic [31:0]         stat_m1_grants,
   output logic [31:0]         stat_stall_cycles,
   output logic                stat_orphan_rdv
`endif
);

   localparam logic [1:0] c_st_idle   = IDLE;
   localparam logic [1:0] c_st_grant0 = GRANT0;
   localparam logic [1:0] c_st_grant1 = GRANT1;
   localparam int         c_hold_w    = $clog2(BURST_LIMIT + 1);
   localparam logic [c_hold_w-1:0] c_hold_max = c_hold_w'(BURST_LIMIT);

   logic                clk;
   logic                rst;
   logic [1:0]          r_state, w_nxt_state, w_oth_state;
   master_id_t          r_last_served, w_nxt_last;
   logic [c_hold_w-1:0] r_hold_cnt, w_nxt_hold, w_hold_inc;
   logic                w_req0, w_req1, w_own_req, w_oth_req;
   logic                w_gnt_valid, w_sel_read, w_read_block, w_wait_sel, w_accept;
   master_id_t          w_gnt_id, w_fifo_head;
   logic                w_fifo_push, w_fifo_pop, w_fifo_full, w_fifo_empty;

   assign clk = clk_clk;
   assign rst = reset_reset;

   assign w_req0      = m0_read | m0_write;
   assign w_req1      = m1_read | m1_write;
   assign w_gnt_valid = (r_state == c_st_grant0) || (r_state == c_st_grant1);
   assign w_gnt_id    = (r_state == c_st_grant1) ? ID_M1 : ID_M0;
   assign w_own_req   = (w_gnt_id == ID_M1) ? w_req1 : w_req0;
   assign w_oth_req   = (other_id(w_gnt_id) == ID_M1) ? w_req1 : w_req0;
   assign w_oth_state = (w_gnt_id == ID_M1) ? c_st_grant0 : c_st_grant1;
   assign w_sel_read  = (w_gnt_id == ID_M1) ? m1_read : m0_read;

   assign w_fifo_pop   = s_readdatavalid & ~w_fifo_empty;
   assign w_read_block = w_fifo_full & ~w_fifo_pop;

   assign s_address    = (w_gnt_id == ID_M1) ? m1_address    : m0_address;
   assign s_writedata  = (w_gnt_id == ID_M1) ? m1_writedata  : m0_writedata;
   assign s_byteenable = (w_gnt_id == ID_M1) ? m1_byteenable : m0_byteenable;
   assign s_read       = w_gnt_valid & w_sel_read & ~w_read_block;
   assign s_write      = w_gnt_valid & ((w_gnt_id == ID_M1) ? m1_write : m0_write);

   // The FIFO-full stall only applies to reads; a stalled write would otherwise be
   // accepted by the controller while the master still sees waitrequest.
   assign w_wait_sel     = s_waitrequest | (w_read_block & w_sel_read);
   assign m0_waitrequest = ~(w_gnt_valid & (w_gnt_id == ID_M0)) | w_wait_sel;
   assign m1_waitrequest = ~(w_gnt_valid & (w_gnt_id == ID_M1)) | w_wait_sel;

   assign w_accept    = (s_read | s_write) & ~s_waitrequest;
   assign w_fifo_push = w_accept & s_read;

   assign m0_readdata      = s_readdata;
   assign m1_readdata      = s_readdata;
   assign m0_readdatavalid = w_fifo_pop & (w_fifo_head == ID_M0);
   assign m1_readdatavalid = w_fifo_pop & (w_fifo_head == ID_M1);

   assign w_hold_inc = (r_hold_cnt == c_hold_max) ? c_hold_max : r_hold_cnt + c_hold_w'(1);

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_last  = r_last_served;
      w_nxt_hold  = r_hold_cnt;
      case (r_state)
         c_st_idle: begin
            if (w_req0 && w_req1)
               w_nxt_state = (r_last_served == ID_M1) ? c_st_grant0 : c_st_grant1;
            else if (w_req0)
               w_nxt_state = c_st_grant0;
            else if (w_req1)
               w_nxt_state = c_st_grant1;
         end
         c_st_grant0, c_st_grant1: begin
            if (!w_own_req) begin
               w_nxt_state = w_oth_req ? w_oth_state : c_st_idle;
               w_nxt_last  = w_gnt_id;
               w_nxt_hold  = '0;
            end else if (w_accept) begin
               if ((w_hold_inc == c_hold_max) && w_oth_req) begin
                  w_nxt_state = w_oth_state;
                  w_nxt_last  = w_gnt_id;
                  w_nxt_hold  = '0;
               end else begin
                  w_nxt_hold  = w_hold_inc;
               end
            end
         end
         default: w_nxt_state = c_st_idle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= c_st_idle;
         r_last_served <= ID_M1;
         r_hold_cnt    <= '0;
      end else begin
         r_state       <= w_nxt_state;
         r_last_served <= w_nxt_last;
         r_hold_cnt    <= w_nxt_hold;
      end
   end

   arb_id_fifo #(
      .DEPTH (MAX_PEND),
      .WIDTH (1)
   ) u_id_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_fifo_push),
      .i_pop   (w_fifo_pop),
      .i_data  (w_gnt_id),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_head  (w_fifo_head)
   );

`ifdef SDRAM_ARB_STATS_EN
   logic [31:0] r_stat_m0, r_stat_m1, r_stat_stall;
   logic        r_stat_orphan;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_m0     <= '0;
         r_stat_m1     <= '0;
         r_stat_stall  <= '0;
         r_stat_orphan <= 1'b0;
      end else if (stat_clear) begin
         r_stat_m0     <= '0;
         r_stat_m1     <= '0;
         r_stat_stall  <= '0;
         r_stat_orphan <= 1'b0;
      end else begin
         if (w_accept && (w_gnt_id == ID_M0) && (r_stat_m0 != '1)) r_stat_m0 <= r_stat_m0 + 32'd1;
         if (w_accept && (w_gnt_id == ID_M1) && (r_stat_m1 != '1)) r_stat_m1 <= r_stat_m1 + 32'd1;
         if ((w_req0 || w_req1) && !w_accept && (r_stat_stall != '1))
            r_stat_stall <= r_stat_stall + 32'd1;
         if (s_readdatavalid && w_fifo_empty) r_stat_orphan <= 1'b1;
      end
   end

   assign stat_m0_grants    = r_stat_m0;
   assign stat_m1_grants    = r_stat_m1;
   assign stat_stall_cycles = r_stat_stall;
   assign stat_orphan_rdv   = r_stat_orphan;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdram_port_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sdram_port_arbiter : scoreboard bench with a 3-cycle SDRAM model |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_sdram_port_arbiter;

   typedef struct packed {
      logic        id;
      logic [31:0] data;
   } exp_t;

   typedef struct {
      logic [31:0] data;
      int          due;
   } ret_t;

   logic        clk = 1'b0;
   logic        reset_reset;
   logic [23:0] m0_address, m1_address;
   logic        m0_read, m0_write, m1_read, m1_write;
   logic [31:0] m0_writedata, m1_writedata;
   logic [3:0]  m0_byteenable, m1_byteenable;
   logic        m0_waitrequest, m1_waitrequest;
   logic [31:0] m0_readdata, m1_readdata;
   logic        m0_readdatavalid, m1_readdatavalid;
   logic [23:0] s_address;
   logic [31:0] s_writedata;
   logic [3:0]  s_byteenable;
   logic        s_read, s_write;
   logic        s_waitrequest   = 1'b0;
   logic [31:0] s_readdata      = 32'h0;
   logic        s_readdatavalid = 1'b0;
`ifdef SDRAM_ARB_STATS_EN
   logic        stat_clear;
   logic [31:0] stat_m0_grants, stat_m1_grants, stat_stall_cycles;
   logic        stat_orphan_rdv;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   ret_t        ret_q[$];
   logic [55:0] wr_log[$];
   int          cyc = 0;
   int          rd_acc = 0;
   int          acc_cnt[2];
   int          wq[40];
   int          snap, w0, w1, base;
   logic        sw_toggle = 1'b0;
   logic        rdv_hold  = 1'b0;

   always #5 clk = ~clk;

   sdram_port_arbiter dut (
      .clk_clk          (clk),
      .reset_reset      (reset_reset),
      .m0_address       (m0_address),
      .m0_read          (m0_read),
      .m0_write         (m0_write),
      .m0_writedata     (m0_writedata),
      .m0_byteenable    (m0_byteenable),
      .m0_waitrequest   (m0_waitrequest),
      .m0_readdata      (m0_readdata),
      .m0_readdatavalid (m0_readdatavalid),
      .m1_address       (m1_address),
      .m1_read          (m1_read),
      .m1_write         (m1_write),
      .m1_writedata     (m1_writedata),
      .m1_byteenable    (m1_byteenable),
      .m1_waitrequest   (m1_waitrequest),
      .m1_readdata      (m1_readdata),
      .m1_readdatavalid (m1_readdatavalid),
      .s_address        (s_address),
      .s_writedata      (s_writedata),
      .s_byteenable     (s_byteenable),
      .s_read           (s_read),
      .s_write          (s_write),
      .s_waitrequest    (s_waitrequest),
      .s_readdata       (s_readdata),
      .s_readdatavalid  (s_readdatavalid)
`ifdef SDRAM_ARB_STATS_EN
      ,
      .stat_clear        (stat_clear),
      .stat_m0_grants    (stat_m0_grants),
      .stat_m1_grants    (stat_m1_grants),
      .stat_stall_cycles (stat_stall_cycles),
      .stat_orphan_rdv   (stat_orphan_rdv)
`endif
   );

   function automatic logic [31:0] mkdata(input logic [23:0] addr);
      return {8'hA5, addr};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // SDRAM controller model: read data returns 3 cycles after acceptance.
   always @(negedge clk) begin
      #1;
      s_waitrequest = sw_toggle ? cyc[0] : 1'b0;
      if (!rdv_hold && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
         s_readdatavalid = 1'b1;
         s_readdata      = ret_q[0].data;
         void'(ret_q.pop_front());
      end else begin
         s_readdatavalid = 1'b0;
         s_readdata      = 32'h0;
      end
      #1;
      if (s_read && !s_waitrequest) begin
         ret_q.push_back('{mkdata(s_address), cyc + 3});
         rd_acc++;
      end
      if (s_write && !s_waitrequest) wr_log.push_back({s_address, s_writedata});
      cyc++;
   end

   // Return-path monitor: every strobe must match the oldest expected read.
   always @(negedge clk) begin
      #2;
      if (m0_readdatavalid || m1_readdatavalid) begin
         if (sb.size() == 0) begin
            check("rdv_unexpected", 64'({m1_readdatavalid, m0_readdatavalid}), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("rdv_route", 64'({m1_readdatavalid, m0_readdatavalid}),
                  mon_e.id ? 64'd2 : 64'd1);
            check("rdv_data", 64'(mon_e.id ? m1_readdata : m0_readdata), 64'(mon_e.data));
         end
      end
   end

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset_reset = 1'b1;
      repeat (2) @(negedge clk);
      sb.delete();
      reset_reset = 1'b0;
   endtask

   task automatic m_idle(input logic id);
      @(negedge clk);
      if (id) begin m1_read = 1'b0; m1_write = 1'b0; end
      else    begin m0_read = 1'b0; m0_write = 1'b0; end
   endtask

   task automatic m_cmd(input logic id, input logic wr, input logic [23:0] addr,
                        input logic [31:0] data, output int waits);
      logic wait_now;
      @(negedge clk);
      if (id) begin
         m1_address = addr; m1_writedata = data; m1_byteenable = 4'h3;
         m1_read = ~wr; m1_write = wr;
      end else begin
         m0_address = addr; m0_writedata = data; m0_byteenable = 4'hF;
         m0_read = ~wr; m0_write = wr;
      end
      waits = 0;
      forever begin
         #3;
         wait_now = id ? m1_waitrequest : m0_waitrequest;
         if (!wait_now || waits == 200) break;
         waits++;
         @(negedge clk);
      end
      check("cmd_accept_bound", 64'(wait_now), 64'd0);
      if (!wait_now) begin
         check("cmd_address", 64'(s_address), 64'(addr));
         check("cmd_strobe", 64'({s_read, s_write}), wr ? 64'd1 : 64'd2);
         check("cmd_byteenable", 64'(s_byteenable), id ? 64'h3 : 64'hF);
         if (wr) check("cmd_writedata", 64'(s_writedata), 64'(data));
         else    sb.push_back({id, mkdata(addr)});
         acc_cnt[id]++;
      end
   endtask

   initial begin
      reset_reset = 1'b1;
      m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
      m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
`ifdef SDRAM_ARB_STATS_EN
      stat_clear = 1'b0;
`endif
      acc_cnt[0] = 0; acc_cnt[1] = 0;
      cycles(3);
      #3;
      check("rst_s_read", 64'(s_read), 64'd0);
      check("rst_s_write", 64'(s_write), 64'd0);
      check("rst_m0_wait", 64'(m0_waitrequest), 64'd1);
      check("rst_m1_wait", 64'(m1_waitrequest), 64'd1);
      check("rst_rdv", 64'({m1_readdatavalid, m0_readdatavalid}), 64'd0);
      @(negedge clk);
      reset_reset = 1'b0;

      // 1: m0 alone, four pipelined reads
      for (int i = 0; i < 4; i++) begin
         m_cmd(1'b0, 1'b0, 24'(24'h10 + i), 32'h0, w0);
         check("t1_wait", 64'(w0), (i == 0) ? 64'd1 : 64'd0);
      end
      m_idle(1'b0);
      cycles(8);
      check("t1_drain", 64'(sb.size()), 64'd0);

      // 2: simultaneous requests after reset
      apply_reset();
      fork
         begin : b_t2_m0
            m_cmd(1'b0, 1'b0, 24'h20, 32'h0, w0);
            m_idle(1'b0);
         end
         begin : b_t2_m1
            m_cmd(1'b1, 1'b0, 24'h30, 32'h0, w1);
            m_idle(1'b1);
         end
      join
      check("t2_m0_first", 64'(w0), 64'd1);
      check("t2_m1_next", 64'(w1), 64'd3);
      cycles(8);
      check("t2_drain", 64'(sb.size()), 64'd0);

      // 3: fairness cap against a 40-write stream
      apply_reset();
      wr_log.delete();
      acc_cnt[0] = 0;
      fork
         begin : b_t3_m0
            int w;
            for (int i = 0; i < 40; i++) begin
               m_cmd(1'b0, 1'b1, 24'(24'h400 + i), 32'hD000_0000 + i, w);
               wq[i] = w;
            end
            m_idle(1'b0);
         end
         begin : b_t3_m1
            int w;
            m_cmd(1'b1, 1'b0, 24'h500, 32'h0, w);
            w1   = w;
            snap = acc_cnt[0];
            m_idle(1'b1);
         end
      join
      check("t3_switch_after", 64'(snap), 64'd16);
      check("t3_m1_wait", 64'(w1), 64'd17);
      check("t3_m0_first_wait", 64'(wq[0]), 64'd1);
      check("t3_m0_back", 64'(wq[16]), 64'd2);
      check("t3_m0_last_wait", 64'(wq[39]), 64'd0);
      check("t3_write_count", 64'(wr_log.size()), 64'd40);
      for (int i = 0; i < 40 && i < wr_log.size(); i++)
         check("t3_write_order", 64'(wr_log[i]), 64'({24'(24'h400 + i), 32'hD000_0000 + i}));
      cycles(8);
      check("t3_drain", 64'(sb.size()), 64'd0);

      // 4: interleaved reads under a toggling controller stall
      sw_toggle = 1'b1;
      base = rd_acc;
      m_cmd(1'b0, 1'b0, 24'h100, 32'h0, w0); m_idle(1'b0);
      m_cmd(1'b1, 1'b0, 24'h200, 32'h0, w1); m_idle(1'b1);
      m_cmd(1'b0, 1'b0, 24'h101, 32'h0, w0); m_idle(1'b0);
      cycles(10);
      sw_toggle = 1'b0;
      check("t4_read_count", 64'(rd_acc - base), 64'd3);
      check("t4_drain", 64'(sb.size()), 64'd0);

      // 5: FIFO full blocks reads; a return frees the slot in the same cycle
      rdv_hold = 1'b1;
      for (int i = 0; i < 8; i++) m_cmd(1'b0, 1'b0, 24'(24'h300 + i), 32'h0, w0);
      @(negedge clk);
      m0_address = 24'h308;
      m0_read    = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #3;
         check("t5_read_blocked", 64'(s_read), 64'd0);
         check("t5_wait_blocked", 64'(m0_waitrequest), 64'd1);
         @(negedge clk);
      end
      rdv_hold = 1'b0;
      #3;
      check("t5_pushpop_read", 64'(s_read), 64'd1);
      check("t5_pushpop_wait", 64'(m0_waitrequest), 64'd0);
      sb.push_back({1'b0, mkdata(24'h308)});
      m_idle(1'b0);
      cycles(16);
      check("t5_drain", 64'(sb.size()), 64'd0);

      // 6: reset with reads in flight, stale returns must be dropped
      rdv_hold = 1'b1;
      for (int i = 0; i < 3; i++) m_cmd(1'b0, 1'b0, 24'(24'h600 + i), 32'h0, w0);
      m_idle(1'b0);
      cycles(2);
      apply_reset();
      #3;
      check("t6_m0_wait", 64'(m0_waitrequest), 64'd1);
      check("t6_m1_wait", 64'(m1_waitrequest), 64'd1);
      check("t6_s_read", 64'(s_read), 64'd0);
      rdv_hold = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         #3;
         check("t6_stale_rdv", 64'({m1_readdatavalid, m0_readdatavalid}), 64'd0);
      end
`ifdef SDRAM_ARB_STATS_EN
      check("t6_orphan", 64'(stat_orphan_rdv), 64'd1);
`endif
      m_cmd(1'b1, 1'b0, 24'h700, 32'h0, w1);
      check("t6_idle_grant", 64'(w1), 64'd1);
      m_idle(1'b1);
      cycles(8);
      check("t6_drain", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", n_vec);
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
